// File: rtl/vx_tcu_tile_agu.sv
// vx_tcu_tile_agu: walks a rows x cols tile row-major, emitting one element address per request handshake.
`ifndef XLEN
`define XLEN 32
`endif
module vx_tcu_tile_agu #(
   parameter  int XLEN       = `XLEN,
   parameter  int MAX_ROWS   = 16,
   parameter  int MAX_COLS   = 16,
   parameter  int ELEM_BYTES = 4,
   localparam int RW         = $clog2(MAX_ROWS + 1),
   localparam int CW         = $clog2(MAX_COLS + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [XLEN-1:0] cmd_base,
   input  logic [XLEN-1:0] cmd_stride,
   input  logic [RW-1:0]   cmd_rows,
   input  logic [CW-1:0]   cmd_cols,
   input  logic            cmd_load,
   output logic            req_valid,
   input  logic            req_ready,
   output logic [XLEN-1:0] req_addr,
   output logic            req_load,
   output logic            busy,
   output logic            done
);
   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
   state_t state, state_n;
   logic [XLEN-1:0] stride_q, row_base;
   logic [RW-1:0] rows_q, row_cnt;
   logic [CW-1:0] cols_q, col_cnt;
   logic accept, fire, last_col, last_row;
   assign accept    = cmd_valid && cmd_ready;
   assign fire      = req_valid && req_ready;
   assign last_col  = col_cnt == cols_q - CW'(1);
   assign last_row  = row_cnt == rows_q - RW'(1);
   assign cmd_ready = state == IDLE && !reset;
   assign req_valid = state == ISSUE;
   assign busy      = state != IDLE;
   assign done      = state == DONE;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = (cmd_rows == '0 || cmd_cols == '0) ? DONE : ISSUE;
         ISSUE:   if (fire && last_col && last_row) state_n = DONE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end
   // Row starts are accumulated so the next row address is a single add, no multiply.
   always_ff @(posedge clk) begin
      if (reset) begin
         req_addr <= '0;
         req_load <= 1'b0;
         row_base <= '0;
         stride_q <= '0;
         rows_q   <= '0;
         cols_q   <= '0;
         row_cnt  <= '0;
         col_cnt  <= '0;
      end else if (accept) begin
         req_addr <= cmd_base;
         req_load <= cmd_load;
         row_base <= cmd_base;
         stride_q <= cmd_stride;
         rows_q   <= cmd_rows;
         cols_q   <= cmd_cols;
         row_cnt  <= '0;
         col_cnt  <= '0;
      end else if (fire && last_col) begin
         row_base <= row_base + stride_q;
         req_addr <= row_base + stride_q;
         col_cnt  <= '0;
         row_cnt  <= row_cnt + RW'(1);
      end else if (fire) begin
         req_addr <= req_addr + XLEN'(ELEM_BYTES);
         col_cnt  <= col_cnt + CW'(1);
      end
   end
endmodule

// File: tb/tb_vx_tcu_tile_agu.sv
// tb_vx_tcu_tile_agu: directed checks of the tile address walk, stalls, wrap, zero-size and mid-run reset.
module tb_vx_tcu_tile_agu;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_base = '0;
   logic [31:0] cmd_stride = '0;
   logic [4:0]  cmd_rows = '0;
   logic [4:0]  cmd_cols = '0;
   logic        cmd_load = 1'b0;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic [31:0] req_addr;
   logic        req_load;
   logic        busy;
   logic        done;
   int checks = 0;
   int errors = 0;
   vx_tcu_tile_agu #(.XLEN(32)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_stride(cmd_stride),
      .cmd_rows(cmd_rows), .cmd_cols(cmd_cols), .cmd_load(cmd_load),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_load(req_load),
      .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask
   // Called at a negedge while idle; returns at the negedge after the accept edge.
   task automatic send_cmd(input logic [31:0] base, input logic [31:0] stride, input int rows,
                           input int cols, input logic ld);
      cmd_base = base; cmd_stride = stride; cmd_rows = 5'(rows); cmd_cols = 5'(cols); cmd_load = ld;
      cmd_valid = 1'b1;
      check("cmd_ready_idle", {31'd0, cmd_ready}, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_base = 32'hDEAD_BEEF; cmd_stride = 32'h1234_5678;
   endtask
   task automatic run_cmd(input logic [31:0] base, input logic [31:0] stride, input int rows,
                          input int cols, input logic ld, input bit rnd);
      int k = 0;
      int cyc = 0;
      bit stall = 0;
      logic [31:0] exp_a;
      logic [31:0] prev_a = '0;
      send_cmd(base, stride, rows, cols, ld);
      while (k < rows * cols && cyc < 200) begin
         req_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stall) begin
            check("stall_valid", {31'd0, req_valid}, 1);
            check("stall_addr", req_addr, prev_a);
         end
         if (!rnd) check("valid_cont", {31'd0, req_valid}, 1);
         check("cmd_ready_busy", {31'd0, cmd_ready}, 0);
         if (req_valid && req_ready) begin
            exp_a = base + 32'(k / cols) * stride + 32'(k % cols) * 4;
            check("addr", req_addr, exp_a);
            check("load", {31'd0, req_load}, {31'd0, ld});
            k++;
            stall = 0;
         end else if (req_valid) begin
            stall = 1;
            prev_a = req_addr;
         end
         @(negedge clk);
         cyc++;
      end
      check("handshakes", k, rows * cols);
      req_ready = 1'b0;
      check("done_pulse", {31'd0, done}, 1);
      check("busy_done", {31'd0, busy}, 1);
      check("valid_done", {31'd0, req_valid}, 0);
      check("cmd_ready_done", {31'd0, cmd_ready}, 0);
      @(negedge clk);
      check("done_clear", {31'd0, done}, 0);
      check("busy_clear", {31'd0, busy}, 0);
      check("cmd_ready_after", {31'd0, cmd_ready}, 1);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      check("rst_valid", {31'd0, req_valid}, 0);
      check("rst_addr", req_addr, 0);
      check("rst_load", {31'd0, req_load}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 0);
      reset = 1'b0;
      @(negedge clk);
      run_cmd(32'h1000, 32'h40, 2, 3, 1'b1, 1'b0);
      run_cmd(32'h1000, 32'h40, 2, 3, 1'b1, 1'b1);
      // zero-sized store
      send_cmd(32'h3000, 32'h10, 0, 4, 1'b0);
      check("zero_done", {31'd0, done}, 1);
      check("zero_busy", {31'd0, busy}, 1);
      check("zero_valid", {31'd0, req_valid}, 0);
      @(negedge clk);
      check("zero_done_clear", {31'd0, done}, 0);
      check("zero_busy_clear", {31'd0, busy}, 0);
      check("zero_valid2", {31'd0, req_valid}, 0);
      check("zero_cmd_ready", {31'd0, cmd_ready}, 1);
      run_cmd(32'hFFFF_FFF8, 32'h10, 2, 3, 1'b0, 1'b0);
      // mid-run reset after 5 handshakes of a 4x4
      send_cmd(32'h5000, 32'h100, 4, 4, 1'b1);
      req_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("rst_run_addr", req_addr, 32'h5000 + 32'(i / 4) * 32'h100 + 32'(i % 4) * 4);
         @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      check("midrst_valid", {31'd0, req_valid}, 0);
      check("midrst_busy", {31'd0, busy}, 0);
      check("midrst_cmd_ready", {31'd0, cmd_ready}, 0);
      check("midrst_done", {31'd0, done}, 0);
      check("midrst_addr", req_addr, 0);
      reset = 1'b0;
      req_ready = 1'b0;
      @(negedge clk);
      check("postrst_done", {31'd0, done}, 0);
      check("postrst_valid", {31'd0, req_valid}, 0);
      run_cmd(32'h7000, 32'h40, 1, 1, 1'b1, 1'b0);
      // back-to-back 1x1 with cmd_valid held
      cmd_base = 32'hA000; cmd_stride = 32'h0; cmd_rows = 5'd1; cmd_cols = 5'd1; cmd_load = 1'b1;
      cmd_valid = 1'b1;
      req_ready = 1'b1;
      @(negedge clk);
      check("b2b_addr1", req_addr, 32'hA000);
      check("b2b_valid1", {31'd0, req_valid}, 1);
      check("b2b_ready_issue", {31'd0, cmd_ready}, 0);
      @(negedge clk);
      cmd_base = 32'hB000; cmd_load = 1'b0;
      check("b2b_done", {31'd0, done}, 1);
      check("b2b_ready_done", {31'd0, cmd_ready}, 0);
      @(negedge clk);
      check("b2b_ready_idle", {31'd0, cmd_ready}, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("b2b_addr2", req_addr, 32'hB000);
      check("b2b_load2", {31'd0, req_load}, 0);
      check("b2b_valid2", {31'd0, req_valid}, 1);
      @(negedge clk);
      check("b2b_done2", {31'd0, done}, 1);
      req_ready = 1'b0;
      @(negedge clk);
      check("b2b_idle", {31'd0, busy}, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
